// File: rtl/mem_stage_pipe.sv
// Memory-stage pipeline register: a two-entry skid buffer carrying the execute-stage
// results toward memory/writeback. The head entry drives the outputs; the skid entry
// catches one extra beat so in_ready can be a pure register.
module mem_stage_pipe #(
    parameter int unsigned PC_W    = 5,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_W   = 5,
    parameter int unsigned JT_IN_W = 4,
    parameter int unsigned JT_W    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_write_data,
    input  logic [JT_IN_W-1:0] in_jump_type,
    input  logic              in_reg_wrenable,
    input  logic [REG_W-1:0]  in_write_reg,
    input  logic              in_mem_wrenable,
    input  logic              in_mem_to_reg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_alu_res,
    output logic [DATA_W-1:0] out_write_data,
    output logic [JT_W-1:0]   out_jump_type,
    output logic              out_reg_wrenable,
    output logic [REG_W-1:0]  out_write_reg,
    output logic              out_mem_wrenable,
    output logic              out_mem_to_reg
);

    if (JT_W > JT_IN_W) begin : g_jt_width_check
        $error("JT_W must not exceed JT_IN_W");
    end

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] alu_res;
        logic [DATA_W-1:0] write_data;
        logic [JT_W-1:0]   jump_type;
        logic              reg_wrenable;
        logic [REG_W-1:0]  write_reg;
        logic              mem_wrenable;
        logic              mem_to_reg;
    } entry_t;

    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    logic   head_valid_q, head_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   ready_q, ready_d;

    entry_t in_entry;
    logic   accept;
    logic   consume;

    // Only the upper JT_W bits of the jump type are kept.
    logic   unused_jt;
    assign unused_jt = ^in_jump_type;

    // Pack the incoming fields into one entry.
    always_comb begin
        in_entry              = '0;
        in_entry.pc           = in_pc;
        in_entry.alu_res      = in_alu_res;
        in_entry.write_data   = in_write_data;
        in_entry.jump_type    = in_jump_type[JT_IN_W-1 -: JT_W];
        in_entry.reg_wrenable = in_reg_wrenable;
        in_entry.write_reg    = in_write_reg;
        in_entry.mem_wrenable = in_mem_wrenable;
        in_entry.mem_to_reg   = in_mem_to_reg;
    end

    assign accept  = in_valid & ready_q & ~flush;
    assign consume = head_valid_q & out_ready;

    // Next-state: head refills from skid first (older), then from the input.
    always_comb begin
        head_d       = head_q;
        skid_d       = skid_q;
        head_valid_d = head_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (consume || !head_valid_q) begin
            if (skid_valid_q) begin
                head_d       = skid_q;
                head_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                head_d       = in_entry;
                head_valid_d = 1'b1;
            end else begin
                head_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end
        // Ready is a register: we can take a beat whenever the skid slot will be free.
        ready_d = ~skid_valid_d;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q       <= '0;
            skid_q       <= '0;
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            head_q       <= head_d;
            skid_q       <= skid_d;
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
        end
    end

    assign in_ready         = ready_q;
    assign out_valid        = head_valid_q;
    assign out_pc           = head_q.pc;
    assign out_alu_res      = head_q.alu_res;
    assign out_write_data   = head_q.write_data;
    assign out_jump_type    = head_q.jump_type;
    assign out_write_reg    = head_q.write_reg;
    // Control bits must never leak from an empty head.
    assign out_reg_wrenable = head_q.reg_wrenable & head_valid_q;
    assign out_mem_wrenable = head_q.mem_wrenable & head_valid_q;
    assign out_mem_to_reg   = head_q.mem_to_reg & head_valid_q;

endmodule
